// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: fetch FSM states
// and the EX operand forwarding select encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        IDROP = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Forwarding select for one EX source operand; the younger MEM result wins
// over WB, and x0 is never forwarded.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline, including
// handling of a slow, non-abortable instruction memory and stale fetch drops.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             imem_valid,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             imem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              lw_stall;

    forward_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    // A taken branch squashes the load in EX's dependent, so no stall is needed then.
    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

    always_comb begin
        state_next = state;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        if (PCSrcE) begin
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            state_next = imem_valid ? RUN : IDROP;
        end else begin
            case (state)
                RUN, IWAIT: begin
                    if (!imem_valid) begin
                        state_next = IWAIT;
                        StallF     = 1'b1;
                        FlushD     = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
                IDROP: begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                    if (imem_valid) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
        // The held DEC instruction must survive, so the stall wins over any bubble.
        if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            FlushD = 1'b0;
        end
        if (rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        wait_next = wait_cnt;
        if (imem_valid) begin
            wait_next = '0;
        end else if (((state == IWAIT) || (state == IDROP)) && (wait_cnt != WAIT_MAX)) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            imem_timeout <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (wait_next == WAIT_MAX) begin
                imem_timeout <= 1'b1;
            end
            if (StallF && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (PCSrcE && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
